// File: rtl/tour_swap_ctrl_pkg.sv
// rtl/tour_swap_ctrl_pkg.sv - shared state encoding, checker-bus widths and index-width helper
package tour_swap_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_FETCH, S_CHECK, S_WAIT, S_SWAP, S_NEXT, S_DONE
  } state_t;

  localparam int COORD_W = 8;
  localparam int DIFF_W  = 19;
  localparam int GAIN_W  = 24;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tour_swap_ctrl_ram.sv
// rtl/tour_swap_ctrl_ram.sv - tour_ram: N_CITY x IDX_W tour storage, one write port, one sync read port
module tour_ram #(
  parameter int N_CITY = 64,
  parameter int IDX_W  = 6
) (
  input  logic             clk,
  input  logic             fsm_sel,
  input  logic [IDX_W-1:0] fsm_addr,
  input  logic [IDX_W-1:0] rd_pos,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [IDX_W-1:0] wdata,
  output logic [IDX_W-1:0] rdata
);

  logic [IDX_W-1:0] mem [N_CITY];
  logic [IDX_W-1:0] raddr;

  // External readout only gets the port while the optimiser is idle.
  assign raddr = fsm_sel ? fsm_addr : rd_pos;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/tour_swap_ctrl.sv
// rtl/tour_swap_ctrl.sv - adjacent-swap tour optimiser FSM; TOUR_SWAP_GAIN_EN enables total_gain accumulation
module tour_swap_ctrl
  import tour_swap_ctrl_pkg::*;
#(
  parameter int  N_CITY   = 64,
  parameter int  MAX_PASS = 16,
  localparam int IDX_W    = idx_w(N_CITY)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               converged,
  output logic [7:0]         pass_cnt,
  output logic [15:0]        swap_cnt,
  output logic [IDX_W-1:0]   coord_addr,
  input  logic [COORD_W-1:0] coord_x,
  input  logic [COORD_W-1:0] coord_y,
  output logic               chk_rst,
  output logic [COORD_W-1:0] chk_x1,
  output logic [COORD_W-1:0] chk_y1,
  output logic [COORD_W-1:0] chk_x2,
  output logic [COORD_W-1:0] chk_y2,
  output logic [COORD_W-1:0] chk_x3,
  output logic [COORD_W-1:0] chk_y3,
  output logic [COORD_W-1:0] chk_x4,
  output logic [COORD_W-1:0] chk_y4,
  input  logic               chk_res,
  input  logic               chk_complete,
  input  logic [DIFF_W-1:0]  chk_diff,
  input  logic [IDX_W-1:0]   rd_pos,
  output logic [IDX_W-1:0]   rd_city,
  output logic [GAIN_W-1:0]  total_gain
);

  localparam logic [IDX_W:0]   N_W   = (IDX_W+1)'(N_CITY);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(N_CITY - 1);
  localparam logic [7:0]       MAX_P = 8'(MAX_PASS);

  state_t             state;
  logic [IDX_W-1:0]   i, c2, c3, tour_q, fsm_addr, waddr, wdata;
  logic [2:0]         k;
  logic               sw, pass_swapped, stale, we, chk_take;
  logic [COORD_W-1:0] vx [4];
  logic [COORD_W-1:0] vy [4];

  function automatic logic [IDX_W-1:0] wrap_pos(input logic [IDX_W-1:0] base, input logic [1:0] off);
    logic [IDX_W:0] s;
    s = {1'b0, base} + (IDX_W+1)'(off);
    if (s >= N_W) s = s - N_W;
    return s[IDX_W-1:0];
  endfunction

  assign fsm_addr   = wrap_pos(i, k[2:1]);
  assign we         = (state == S_INIT) || (state == S_SWAP);
  assign waddr      = (state == S_INIT) ? i : wrap_pos(i, sw ? 2'd2 : 2'd1);
  assign wdata      = (state == S_INIT) ? i : (sw ? c2 : c3);
  // complete is a stale level for the pulse cycle and the one after it
  assign chk_take   = (state == S_WAIT) && chk_complete && !chk_rst && !stale;
  assign coord_addr = tour_q;
  assign rd_city    = tour_q;
  assign chk_x1 = vx[0];
  assign chk_y1 = vy[0];
  assign chk_x2 = vx[1];
  assign chk_y2 = vy[1];
  assign chk_x3 = vx[2];
  assign chk_y3 = vy[2];
  assign chk_x4 = vx[3];
  assign chk_y4 = vy[3];

  tour_ram #(.N_CITY(N_CITY), .IDX_W(IDX_W)) u_tour_ram (
    .clk      (clk),
    .fsm_sel  (busy),
    .fsm_addr (fsm_addr),
    .rd_pos   (rd_pos),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .rdata    (tour_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      converged    <= 1'b0;
      pass_cnt     <= '0;
      swap_cnt     <= '0;
      chk_rst      <= 1'b0;
      i            <= '0;
      k            <= '0;
      sw           <= 1'b0;
      pass_swapped <= 1'b0;
      stale        <= 1'b0;
    end else begin
      chk_rst <= 1'b0;
      stale   <= chk_rst;
      case (state)
        S_IDLE, S_DONE: if (start) begin
          state        <= S_INIT;
          busy         <= 1'b1;
          done         <= 1'b0;
          converged    <= 1'b0;
          pass_cnt     <= '0;
          swap_cnt     <= '0;
          pass_swapped <= 1'b0;
          i            <= '0;
        end
        S_INIT: begin
          if (i == LAST) begin
            i     <= '0;
            k     <= '0;
            state <= S_FETCH;
          end else begin
            i <= i + 1'b1;
          end
        end
        // even k: tour read issued, odd k: city on coord_addr, coord lands one k later
        S_FETCH: begin
          if (k == 3'd3) c2 <= tour_q;
          if (k == 3'd5) c3 <= tour_q;
          if (!k[0] && k != 3'd0) begin
            vx[k[2:1] - 2'd1] <= coord_x;
            vy[k[2:1] - 2'd1] <= coord_y;
          end
          k <= k + 3'd1;
          if (k == 3'd7) state <= S_CHECK;
        end
        S_CHECK: begin
          vx[3]   <= coord_x;
          vy[3]   <= coord_y;
          chk_rst <= 1'b1;
          state   <= S_WAIT;
        end
        S_WAIT: if (chk_take) begin
          state <= chk_res ? S_SWAP : S_NEXT;
          sw    <= 1'b0;
        end
        S_SWAP: begin
          sw <= 1'b1;
          if (sw) begin
            state        <= S_NEXT;
            pass_swapped <= 1'b1;
            if (swap_cnt != 16'hFFFF) swap_cnt <= swap_cnt + 16'd1;
          end
        end
        S_NEXT: begin
          k <= '0;
          if (i != LAST) begin
            i     <= i + 1'b1;
            state <= S_FETCH;
          end else begin
            i        <= '0;
            pass_cnt <= pass_cnt + 8'd1;
            if (!pass_swapped) begin
              state     <= S_DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              converged <= 1'b1;
            end else if (pass_cnt + 8'd1 == MAX_P) begin
              state     <= S_DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              converged <= 1'b0;
            end else begin
              pass_swapped <= 1'b0;
              state        <= S_FETCH;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef TOUR_SWAP_GAIN_EN
  logic [GAIN_W-1:0] gain;
  logic [GAIN_W:0]   gain_sum;

  assign gain_sum   = {1'b0, gain} + (GAIN_W+1)'(chk_diff);
  assign total_gain = gain;

  always_ff @(posedge clk) begin
    if (rst) begin
      gain <= '0;
    end else if ((state == S_IDLE || state == S_DONE) && start) begin
      gain <= '0;
    end else if (chk_take && chk_res) begin
      gain <= gain_sum[GAIN_W] ? '1 : gain_sum[GAIN_W-1:0];
    end
  end
`else
  logic unused_diff;
  assign unused_diff = ^chk_diff;
  assign total_gain  = '0;
`endif

endmodule

// File: doc/tour_swap_ctrl.md
TOUR_SWAP_CTRL -- requirements
Module: tour_swap_ctrl

Interface
REQ-001 SHALL have parameter N_CITY, default 64, cities in tour (>=4).
REQ-002 SHALL have parameter MAX_PASS, default 16, pass limit before forced stop.
REQ-003 SHALL have localparam IDX_W = clog2(N_CITY), default 6, city/position index width.
REQ-004 clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  begin optimisation; ignored while busy.
REQ-006 busy  out  1  high from accepted start until done.
REQ-007 done  out  1  level; high after finish until next accepted start.
REQ-008 converged  out  1  last pass made zero swaps; valid when done.
REQ-009 pass_cnt  out  8  passes completed; swap_cnt  out  16  swaps performed.
REQ-010 coord_addr  out  IDX_W  city index to coordinate ROM; coord_x, coord_y  in  8 each  ROM data, 1-cycle latency.
REQ-011 chk_rst  out  1  one-cycle start pulse to adjacent-swap checker.
REQ-012 chk_x1..chk_y4  out  8 each  v1..v4 coordinates, held stable from chk_rst until chk_complete.
REQ-013 chk_res  in  1  swap improves; chk_complete  in  1  level result valid; chk_diff  in  19  path1-path2.
REQ-014 rd_pos  in  IDX_W  tour readout position; rd_city  out  IDX_W  city at rd_pos, 1-cycle latency, valid only when busy=0.

Function
REQ-015 SHALL implement states IDLE, INIT, FETCH, CHECK, WAIT, SWAP, NEXT, DONE.
REQ-016 IDLE: start -> INIT; done cleared, counters cleared.
REQ-017 INIT: write tour[p]=p for p=0..N_CITY-1, one per cycle, N_CITY cycles, then i=0 -> FETCH.
REQ-018 FETCH: for k=0..3 read tour[(i+k) mod N_CITY], then coord of that city; 2 cycles per vertex, 8 cycles total; latch cities c1..c4 and coords.
REQ-019 CHECK: drive chk_rst high exactly one cycle with coords already stable -> WAIT.
REQ-020 WAIT: ignore chk_complete in the cycle after chk_rst (stale level); on chk_complete=1 with chk_res=1 -> SWAP, else -> NEXT.
REQ-021 SWAP: write tour[(i+1) mod N]=c3 then tour[(i+2) mod N]=c2, 2 cycles; swap_cnt+1 (saturate at 16'hFFFF); set pass_swapped -> NEXT.
REQ-022 NEXT: i<N_CITY-1 -> i+1, FETCH; at i=N_CITY-1 wrap i=0, pass_cnt+1; if pass_swapped=0 -> DONE converged=1; else if pass_cnt+1==MAX_PASS -> DONE converged=0; else clear pass_swapped, FETCH.
REQ-023 DONE: busy=0, done=1; start -> INIT (restart from identity tour).
REQ-024 Positions SHALL wrap modulo N_CITY for non-power-of-two N_CITY (compare-and-subtract, no bit truncation).
REQ-025 Swap at i SHALL be visible to FETCH at i+1 (write-before-read ordering, no stale read).
REQ-026 chk_diff SHALL be treated unsigned and used only when chk_res=1.
REQ-027 rd_pos readout SHALL not disturb tour contents; rd_city undefined while busy.

Reset
REQ-028 rst SHALL force IDLE, busy=0, done=0, converged=0, pass_cnt=0, swap_cnt=0, chk_rst=0, i=0, from any state incl. mid-SWAP.
REQ-029 Tour RAM contents SHALL not be reset; INIT rebuilds them on every start.

Configuration
REQ-030 Macro TOUR_SWAP_GAIN_EN: when defined, output total_gain out 24 SHALL accumulate chk_diff on each SWAP, saturating at 24'hFFFFFF, cleared by rst and start.
REQ-031 Without TOUR_SWAP_GAIN_EN, total_gain SHALL be driven 0 and its accumulator omitted.

Structure
REQ-032 Shared package SHALL hold state enum, IDX_W helper function and checker-bus coordinate/diff width constants (8, 19).
REQ-033 One sub-module tour_ram SHALL hold N_CITY x IDX_W entries, 1 sync read port, 1 write port; read mux between FSM and rd_pos.

Verification (bench models checker: complete 10 cycles after chk_rst, scripted res/diff)
REQ-034 N_CITY=4, checker res=0 always -> one pass, done with converged=1, pass_cnt=1, swap_cnt=0, tour 0,1,2,3.
REQ-035 N_CITY=4, res=1 diff=25 only first check -> tour 0,2,1,3, swap_cnt=1, pass_cnt=2, converged=1, total_gain=25 (gain enabled).
REQ-036 N_CITY=5, res=1 only at i=4 -> swap writes positions 0 and 1 (wrap): tour 1,0,2,3,4.
REQ-037 res=1 always, MAX_PASS=3 -> done after pass_cnt=3, converged=0, swap_cnt=3*N_CITY.
REQ-038 rst asserted during SWAP second write -> next cycle busy=0, done=0, counters 0; new start yields identity tour.
REQ-039 start pulsed while busy and chk_complete held high from previous check -> start ignored, WAIT does not exit on stale complete.
